// File: rtl/math_unit_seq_pkg.sv
// math_unit_pkg: shared constants for math_unit_seq.
//   - opcode encodings presented on the op port
//   - FSM state encoding (IDLE / MUL)
//   - bit positions of N/Z/C/V inside the packed flags register
package math_unit_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_ADC = 3'b010;
    localparam logic [2:0] OP_SBC = 3'b011;
    localparam logic [2:0] OP_CMP = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_t;

    localparam int FLAG_V    = 0;
    localparam int FLAG_C    = 1;
    localparam int FLAG_Z    = 2;
    localparam int FLAG_N    = 3;
    localparam int NUM_FLAGS = 4;

endpackage

// File: rtl/math_unit_seq_if.sv
// math_unit_seq_if: request/response bundle between the datapath and math_unit_seq.
//   master drives: start, op, a, b
//   slave drives : ready, done, err, result, result_hi, NO, ZO, CO, VO
interface math_unit_seq_if #(
    parameter int WIDTH = 16
) ();
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ready;
    logic             done;
    logic             err;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             NO;
    logic             ZO;
    logic             CO;
    logic             VO;

    modport master (
        output start, op, a, b,
        input  ready, done, err, result, result_hi, NO, ZO, CO, VO
    );

    modport slave (
        input  start, op, a, b,
        output ready, done, err, result, result_hi, NO, ZO, CO, VO
    );
endinterface

// File: rtl/math_unit_seq_add_sub_core.sv
// add_sub_core: combinational WIDTH-bit adder with optional inversion of b.
//   a, b      : operands
//   invert_b  : 1 -> add ~b (subtract when cin=1)
//   cin       : carry in
//   sum       : low WIDTH bits of a + b' + cin
//   cout      : bit WIDTH of the sum
//   ovf       : signed overflow of the addition as performed (on b')
module add_sub_core #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             invert_b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    assign b_eff = invert_b ? ~b : b;
    assign full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    assign sum   = full[WIDTH-1:0];
    assign cout  = full[WIDTH];
    assign ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
endmodule

// File: rtl/math_unit_seq.sv
// math_unit_seq: registered add/sub/compare unit with persistent carry and a
// shift-add unsigned multiplier.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of math_unit_seq_if (start/op/a/b in;
//              ready/done/err/result/result_hi/NO/ZO/CO/VO out)
//
//   state  | meaning
//   S_IDLE | ready; single-cycle ops complete here, MUL is launched here
//   S_MUL  | one shift-add iteration per clock, WIDTH iterations total
module math_unit_seq
    import math_unit_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter bit MUL_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    math_unit_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    state_t                 state, state_nx;
    logic [WIDTH-1:0]       res_q, res_nx;
    logic [WIDTH-1:0]       hi_q, hi_nx;
    logic [NUM_FLAGS-1:0]   flags_q, flags_nx;
    logic                   done_q, done_nx;
    logic                   err_q, err_nx;
    logic [WIDTH-1:0]       mcand_q, mcand_nx;
    logic [WIDTH-1:0]       acc_hi_q, acc_hi_nx;
    logic [WIDTH-1:0]       acc_lo_q, acc_lo_nx;
    logic [CW-1:0]          cnt_q, cnt_nx;

    logic [WIDTH-1:0]       add_a, add_b, sum;
    logic                   add_inv, add_cin, cout, ovf;
    logic [WIDTH-1:0]       prod_hi, prod_lo;
    logic [NUM_FLAGS-1:0]   arith_flags, mul_flags;
    logic                   accept;

    // The single adder serves the ALU ops in IDLE and the accumulate step in MUL.
    always_comb begin
        add_a   = bus.a;
        add_b   = bus.b;
        add_inv = 1'b0;
        add_cin = 1'b0;
        if (state == S_MUL) begin
            add_a = acc_hi_q;
            add_b = acc_lo_q[0] ? mcand_q : '0;
        end else begin
            case (bus.op)
                OP_SUB, OP_CMP: begin add_inv = 1'b1; add_cin = 1'b1;           end
                OP_ADC:         begin                 add_cin = flags_q[FLAG_C]; end
                OP_SBC:         begin add_inv = 1'b1; add_cin = flags_q[FLAG_C]; end
                default:        ;
            endcase
        end
    end

    add_sub_core #(.WIDTH(WIDTH)) u_core (
        .a        (add_a),
        .b        (add_b),
        .invert_b (add_inv),
        .cin      (add_cin),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    // {carry, partial sum, multiplier} shifted right one place per iteration.
    assign prod_hi = {cout, sum[WIDTH-1:1]};
    assign prod_lo = {sum[0], acc_lo_q[WIDTH-1:1]};

    assign arith_flags[FLAG_N] = sum[WIDTH-1];
    assign arith_flags[FLAG_Z] = (sum == '0);
    assign arith_flags[FLAG_C] = cout;
    assign arith_flags[FLAG_V] = ovf;

    assign mul_flags[FLAG_N] = prod_hi[WIDTH-1];
    assign mul_flags[FLAG_Z] = ({prod_hi, prod_lo} == '0);
    assign mul_flags[FLAG_C] = |prod_hi;
    assign mul_flags[FLAG_V] = |prod_hi;

    assign accept = bus.start & (state == S_IDLE);

    always_comb begin
        state_nx  = state;
        res_nx    = res_q;
        hi_nx     = hi_q;
        flags_nx  = flags_q;
        done_nx   = 1'b0;
        err_nx    = 1'b0;
        mcand_nx  = mcand_q;
        acc_hi_nx = acc_hi_q;
        acc_lo_nx = acc_lo_q;
        cnt_nx    = cnt_q;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (bus.op)
                        OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                            res_nx   = sum;
                            hi_nx    = '0;
                            flags_nx = arith_flags;
                            done_nx  = 1'b1;
                        end
                        OP_CMP: begin
                            flags_nx = arith_flags;
                            done_nx  = 1'b1;
                        end
                        OP_MUL: begin
                            if (MUL_EN) begin
                                mcand_nx  = bus.b;
                                acc_lo_nx = bus.a;
                                acc_hi_nx = '0;
                                cnt_nx    = CW'(WIDTH);
                                state_nx  = S_MUL;
                            end else begin
                                done_nx = 1'b1;
                                err_nx  = 1'b1;
                            end
                        end
                        default: begin
                            done_nx = 1'b1;
                            err_nx  = 1'b1;
                        end
                    endcase
                end
            end
            S_MUL: begin
                acc_hi_nx = prod_hi;
                acc_lo_nx = prod_lo;
                cnt_nx    = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    res_nx   = prod_lo;
                    hi_nx    = prod_hi;
                    flags_nx = mul_flags;
                    done_nx  = 1'b1;
                    state_nx = S_IDLE;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            res_q    <= '0;
            hi_q     <= '0;
            flags_q  <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            mcand_q  <= '0;
            acc_hi_q <= '0;
            acc_lo_q <= '0;
            cnt_q    <= '0;
        end else begin
            state    <= state_nx;
            res_q    <= res_nx;
            hi_q     <= hi_nx;
            flags_q  <= flags_nx;
            done_q   <= done_nx;
            err_q    <= err_nx;
            mcand_q  <= mcand_nx;
            acc_hi_q <= acc_hi_nx;
            acc_lo_q <= acc_lo_nx;
            cnt_q    <= cnt_nx;
        end
    end

    assign bus.ready     = (state == S_IDLE);
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.result    = res_q;
    assign bus.result_hi = hi_q;
    assign bus.NO        = flags_q[FLAG_N];
    assign bus.ZO        = flags_q[FLAG_Z];
    assign bus.CO        = flags_q[FLAG_C];
    assign bus.VO        = flags_q[FLAG_V];
endmodule

// File: tb/tb_math_unit_seq.sv
// tb_math_unit_seq: self-checking bench for math_unit_seq (WIDTH=16 and WIDTH=8).
module tb_math_unit_seq;
    import math_unit_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    math_unit_seq_if #(.WIDTH(16)) bus16 ();
    math_unit_seq_if #(.WIDTH(8))  bus8 ();
    math_unit_seq_if #(.WIDTH(8))  bus8n ();

    math_unit_seq #(.WIDTH(16), .MUL_EN(1'b1)) u16  (.clk(clk), .rst(rst), .bus(bus16.slave));
    math_unit_seq #(.WIDTH(8),  .MUL_EN(1'b1)) u8   (.clk(clk), .rst(rst), .bus(bus8.slave));
    math_unit_seq #(.WIDTH(8),  .MUL_EN(1'b0)) u8n  (.clk(clk), .rst(rst), .bus(bus8n.slave));

    int checks = 0;
    int errors = 0;

    // Reference model state for the 16-bit unit.
    logic [15:0] m_res, m_hi;
    logic        m_n, m_z, m_c, m_v;
    // Scoreboard entry: {result, result_hi, N, Z, C, V, err}
    logic [36:0] sb[$];
    logic [36:0] obs16, exp16;

    assign obs16 = {bus16.result, bus16.result_hi, bus16.NO, bus16.ZO, bus16.CO, bus16.VO, bus16.err};

    task automatic model_clear();
        m_res = '0; m_hi = '0; m_n = 0; m_z = 0; m_c = 0; m_v = 0;
    endtask

    task automatic model_push(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] bb;
        logic [31:0] p;
        logic        cin, e;
        e = 1'b0;
        case (op)
            3'b000, 3'b001, 3'b010, 3'b011, 3'b100: begin
                bb  = (op == 3'b001 || op == 3'b011 || op == 3'b100) ? ~b : b;
                cin = (op == 3'b001 || op == 3'b100) ? 1'b1 : (op == 3'b000) ? 1'b0 : m_c;
                s   = {1'b0, a} + {1'b0, bb} + {16'd0, cin};
                if (op != 3'b100) begin m_res = s[15:0]; m_hi = '0; end
                m_n = s[15];
                m_z = (s[15:0] == 16'd0);
                m_c = s[16];
                m_v = (a[15] == bb[15]) && (s[15] != a[15]);
            end
            3'b101: begin
                p = {16'd0, a} * {16'd0, b};
                m_res = p[15:0];
                m_hi  = p[31:16];
                m_z   = (p == 32'd0);
                m_n   = p[31];
                m_c   = (p[31:16] != 16'd0);
                m_v   = m_c;
            end
            default: e = 1'b1;
        endcase
        sb.push_back({m_res, m_hi, m_n, m_z, m_c, m_v, e});
    endtask

    task automatic issue16(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        @(negedge clk);
        bus16.start = 1'b1; bus16.op = op; bus16.a = a; bus16.b = b;
        model_push(op, a, b);
        @(posedge clk);
        #1 bus16.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (obs16 !== 37'd0 || bus16.ready !== 1'b1 || bus16.done !== 1'b0)
            begin errors++; $display("FAIL reset16 got obs=%h rdy=%b done=%b exp obs=0 rdy=1 done=0", obs16, bus16.ready, bus16.done); end
        checks++;
        if ({bus8.result, bus8.result_hi, bus8.NO, bus8.ZO, bus8.CO, bus8.VO, bus8.done, bus8.err} !== 22'd0 || bus8.ready !== 1'b1)
            begin errors++; $display("FAIL reset8 got res=%h hi=%h rdy=%b exp 0 0 1", bus8.result, bus8.result_hi, bus8.ready); end
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_add_ovf();
        issue16(OP_ADD, 16'h7FFF, 16'h0001);
        @(negedge clk);
        exp16 = sb.pop_front();
        checks++;
        if (bus16.done !== 1'b1 || obs16 !== exp16)
            begin errors++; $display("FAIL add_ovf got done=%b obs=%h exp done=1 obs=%h", bus16.done, obs16, exp16); end
        checks++;
        if ({bus16.result, bus16.NO, bus16.VO, bus16.CO, bus16.ZO} !== {16'h8000, 4'b1100})
            begin errors++; $display("FAIL add_ovf_const got res=%h nvcz=%b%b%b%b exp 8000 1100", bus16.result, bus16.NO, bus16.VO, bus16.CO, bus16.ZO); end
        @(negedge clk);
        checks++;
        if (bus16.done !== 1'b0)
            begin errors++; $display("FAIL add_done_pulse got done=%b exp 0", bus16.done); end
    endtask

    task automatic test_sub_cmp();
        issue16(OP_SUB, 16'h0005, 16'h0005);
        @(negedge clk);
        exp16 = sb.pop_front();
        checks++;
        if (bus16.done !== 1'b1 || obs16 !== exp16 || {bus16.result, bus16.ZO, bus16.CO} !== {16'h0000, 2'b11})
            begin errors++; $display("FAIL sub_zero got done=%b obs=%h exp done=1 obs=%h", bus16.done, obs16, exp16); end
        issue16(OP_CMP, 16'h0003, 16'h0005);
        @(negedge clk);
        exp16 = sb.pop_front();
        checks++;
        if (bus16.done !== 1'b1 || obs16 !== exp16 || {bus16.result, bus16.NO, bus16.CO} !== {16'h0000, 2'b10})
            begin errors++; $display("FAIL cmp got done=%b obs=%h exp done=1 obs=%h", bus16.done, obs16, exp16); end
    endtask

    task automatic test_chain();
        issue16(OP_ADD, 16'hFFFF, 16'h0001);
        @(negedge clk);
        exp16 = sb.pop_front();
        checks++;
        if (obs16 !== exp16 || {bus16.result, bus16.CO} !== {16'h0000, 1'b1})
            begin errors++; $display("FAIL chain_add got obs=%h exp %h", obs16, exp16); end
        issue16(OP_ADC, 16'h0000, 16'h0000);
        @(negedge clk);
        exp16 = sb.pop_front();
        checks++;
        if (obs16 !== exp16 || {bus16.result, bus16.CO} !== {16'h0001, 1'b0})
            begin errors++; $display("FAIL chain_adc got obs=%h exp %h", obs16, exp16); end
        issue16(OP_SBC, 16'h0001, 16'h0001);
        @(negedge clk);
        exp16 = sb.pop_front();
        checks++;
        if (obs16 !== exp16 || {bus16.result, bus16.CO, bus16.NO} !== {16'hFFFF, 2'b01})
            begin errors++; $display("FAIL chain_sbc got obs=%h exp %h", obs16, exp16); end
    endtask

    task automatic test_back_to_back();
        logic [2:0]  t_op [6] = '{OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_CMP, 3'b111};
        logic [15:0] t_a  [6] = '{16'h0001, 16'h000A, 16'hFFFF, 16'h0000, 16'h0008, 16'h1234};
        logic [15:0] t_b  [6] = '{16'h0002, 16'h0003, 16'hFFFF, 16'h0000, 16'h0008, 16'h4321};
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i > 0) begin
                exp16 = sb.pop_front();
                checks++;
                if (bus16.done !== 1'b1 || bus16.ready !== 1'b1 || obs16 !== exp16)
                    begin errors++; $display("FAIL b2b_%0d got done=%b obs=%h exp done=1 obs=%h", i - 1, bus16.done, obs16, exp16); end
            end
            if (i < 6) begin
                bus16.start = 1'b1; bus16.op = t_op[i]; bus16.a = t_a[i]; bus16.b = t_b[i];
                model_push(t_op[i], t_a[i], t_b[i]);
            end else begin
                bus16.start = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (bus16.done !== 1'b0 || bus16.err !== 1'b0)
            begin errors++; $display("FAIL b2b_end got done=%b err=%b exp 0 0", bus16.done, bus16.err); end
    endtask

    task automatic test_mul16();
        int bad;
        bad = 0;
        issue16(OP_MUL, 16'hFFFF, 16'hFFFF);
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            if (bus16.ready !== 1'b0 || bus16.done !== 1'b0) bad++;
            if (cyc == 4) begin
                bus16.start = 1'b1; bus16.op = OP_ADD; bus16.a = 16'h0001; bus16.b = 16'h0001;
            end else begin
                bus16.start = 1'b0;
            end
        end
        checks++;
        if (bad != 0)
            begin errors++; $display("FAIL mul16_busy got %0d bad cycles exp 0", bad); end
        @(negedge clk);
        exp16 = sb.pop_front();
        checks++;
        if (bus16.done !== 1'b1 || bus16.ready !== 1'b1 || obs16 !== exp16)
            begin errors++; $display("FAIL mul16_done got done=%b rdy=%b obs=%h exp 1 1 %h", bus16.done, bus16.ready, obs16, exp16); end
        checks++;
        if ({bus16.result, bus16.result_hi, bus16.CO, bus16.VO} !== {16'h0001, 16'hFFFE, 2'b11})
            begin errors++; $display("FAIL mul16_const got res=%h hi=%h c=%b v=%b exp 0001 fffe 1 1", bus16.result, bus16.result_hi, bus16.CO, bus16.VO); end
        @(negedge clk);
        checks++;
        if (bus16.done !== 1'b0)
            begin errors++; $display("FAIL mul16_extra_done got done=%b exp 0", bus16.done); end
    endtask

    task automatic test_reset_mid_mul();
        int bad;
        bad = 0;
        @(negedge clk);
        bus16.start = 1'b1; bus16.op = OP_MUL; bus16.a = 16'h1234; bus16.b = 16'h5678;
        @(posedge clk);
        #1 bus16.start = 1'b0;
        repeat (8) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (obs16 !== 37'd0 || bus16.ready !== 1'b1 || bus16.done !== 1'b0)
            begin errors++; $display("FAIL rst_mid_mul got obs=%h rdy=%b done=%b exp 0 1 0", obs16, bus16.ready, bus16.done); end
        @(negedge clk);
        rst = 1'b0;
        model_clear();
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (bus16.done !== 1'b0 || bus16.ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0)
            begin errors++; $display("FAIL rst_discard got %0d bad cycles exp 0", bad); end
        issue16(OP_ADD, 16'h0002, 16'h0003);
        @(negedge clk);
        exp16 = sb.pop_front();
        checks++;
        if (bus16.done !== 1'b1 || obs16 !== exp16 || bus16.result !== 16'h0005)
            begin errors++; $display("FAIL post_rst_add got done=%b obs=%h exp done=1 obs=%h", bus16.done, obs16, exp16); end
    endtask

    task automatic test_illegal16();
        issue16(3'b110, 16'hAAAA, 16'h5555);
        @(negedge clk);
        exp16 = sb.pop_front();
        checks++;
        if (bus16.done !== 1'b1 || obs16 !== exp16)
            begin errors++; $display("FAIL illegal16 got done=%b obs=%h exp done=1 obs=%h", bus16.done, obs16, exp16); end
        @(negedge clk);
        checks++;
        if (bus16.done !== 1'b0 || bus16.err !== 1'b0)
            begin errors++; $display("FAIL illegal16_pulse got done=%b err=%b exp 0 0", bus16.done, bus16.err); end
    endtask

    task automatic test_mul8();
        logic [15:0] p;
        logic [11:0] exp8;
        int bad;
        bad = 0;
        p = 16'h0010 * 16'h0010;
        exp8 = {p[7:0], (p == 16'd0), p[15], (p[15:8] != 8'd0), (p[15:8] != 8'd0)};
        @(negedge clk);
        bus8.start = 1'b1; bus8.op = OP_MUL; bus8.a = 8'h10; bus8.b = 8'h10;
        @(posedge clk);
        #1 bus8.start = 1'b0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            @(negedge clk);
            if (bus8.done !== 1'b0 || bus8.ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0)
            begin errors++; $display("FAIL mul8_busy got %0d bad cycles exp 0", bad); end
        @(negedge clk);
        checks++;
        if (bus8.done !== 1'b1 || bus8.err !== 1'b0 || bus8.result_hi !== p[15:8] ||
            {bus8.result, bus8.ZO, bus8.NO, bus8.CO, bus8.VO} !== exp8)
            begin errors++; $display("FAIL mul8 got done=%b res=%h hi=%h z=%b exp done=1 res=%h hi=%h z=%b", bus8.done, bus8.result, bus8.result_hi, bus8.ZO, p[7:0], p[15:8], exp8[3]); end
        @(negedge clk);
        bus8.start = 1'b1; bus8.op = 3'b110; bus8.a = 8'h33; bus8.b = 8'h44;
        @(posedge clk);
        #1 bus8.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus8.done !== 1'b1 || bus8.err !== 1'b1 || bus8.result_hi !== p[15:8] ||
            {bus8.result, bus8.ZO, bus8.NO, bus8.CO, bus8.VO} !== exp8)
            begin errors++; $display("FAIL illegal8 got done=%b err=%b res=%h hi=%h exp 1 1 %h %h", bus8.done, bus8.err, bus8.result, bus8.result_hi, p[7:0], p[15:8]); end
        @(negedge clk);
        checks++;
        if (bus8.done !== 1'b0 || bus8.err !== 1'b0)
            begin errors++; $display("FAIL illegal8_pulse got done=%b err=%b exp 0 0", bus8.done, bus8.err); end
    endtask

    task automatic test_mul_disabled();
        @(negedge clk);
        bus8n.start = 1'b1; bus8n.op = OP_MUL; bus8n.a = 8'h03; bus8n.b = 8'h05;
        @(posedge clk);
        #1 bus8n.start = 1'b0;
        @(negedge clk);
        checks++;
        if (bus8n.done !== 1'b1 || bus8n.err !== 1'b1 || bus8n.ready !== 1'b1 ||
            {bus8n.result, bus8n.result_hi, bus8n.NO, bus8n.ZO, bus8n.CO, bus8n.VO} !== 20'd0)
            begin errors++; $display("FAIL mul_disabled got done=%b err=%b rdy=%b res=%h exp 1 1 1 00", bus8n.done, bus8n.err, bus8n.ready, bus8n.result); end
    endtask

    initial begin
        bus16.start = 1'b0; bus16.op = '0; bus16.a = '0; bus16.b = '0;
        bus8.start  = 1'b0; bus8.op  = '0; bus8.a  = '0; bus8.b  = '0;
        bus8n.start = 1'b0; bus8n.op = '0; bus8n.a = '0; bus8n.b = '0;
        model_clear();
        test_reset();
        test_add_ovf();
        test_sub_cmp();
        test_chain();
        test_back_to_back();
        test_mul16();
        test_reset_mid_mul();
        test_illegal16();
        test_mul8();
        test_mul_disabled();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
